// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one fixed-latency memory port between CPU and DMA
module mem_port_arbiter #(
    parameter int WIDTH = 32,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_adr,
    input  logic [WIDTH-1:0] cpu_wd,
    output logic [WIDTH-1:0] cpu_rd,
    output logic             cpu_ack,
    input  logic             dma_req,
    input  logic             dma_we,
    input  logic [WIDTH-1:0] dma_adr,
    input  logic [WIDTH-1:0] dma_wd,
    output logic [WIDTH-1:0] dma_rd,
    output logic             dma_ack,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wd,
    output logic             mem_we,
    input  logic [WIDTH-1:0] mem_rd,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_next;
    logic [3:0] count;
    logic owner, last_gnt, lat_we, grant, gnt_dma, last_cycle;
    // Grant selection (owner 1 = DMA; on a tie the side not served last wins) and next state
    always_comb begin
        grant      = (state == IDLE) && (cpu_req || dma_req);
        gnt_dma    = dma_req && (!cpu_req || !last_gnt);
        last_cycle = (state == ACCESS) && (count == 4'd0);
        state_next = state == IDLE ? (grant ? ACCESS : IDLE) :
                     state == ACCESS ? (last_cycle ? RESP : ACCESS) : IDLE;
    end
    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end
    // Request latch, access countdown and read-data capture into the owner's register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner    <= 1'b0;
            last_gnt <= 1'b1;
            lat_we   <= 1'b0;
            count    <= 4'd0;
            mem_adr  <= '0;
            mem_wd   <= '0;
            cpu_rd   <= '0;
            dma_rd   <= '0;
        end else begin
            if (grant) begin
                owner    <= gnt_dma;
                last_gnt <= gnt_dma;
                lat_we   <= gnt_dma ? dma_we : cpu_we;
                mem_adr  <= gnt_dma ? dma_adr : cpu_adr;
                mem_wd   <= gnt_dma ? dma_wd : cpu_wd;
                count    <= 4'(LAT - 1);
            end else if (state == ACCESS && count != 4'd0) begin
                count <= count - 4'd1;
            end
            if (last_cycle && !lat_we && !owner) cpu_rd <= mem_rd;
            if (last_cycle && !lat_we && owner)  dma_rd <= mem_rd;
        end
    end
    assign mem_we  = last_cycle && lat_we;
    assign busy    = state != IDLE;
    assign cpu_ack = (state == RESP) && !owner;
    assign dma_ack = (state == RESP) && owner;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latency, write commit and reset abort
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
    logic [31:0] cpu_adr = 0, cpu_wd = 0, dma_adr = 0, dma_wd = 0;
    logic [31:0] cpu_rd, dma_rd, mem_adr, mem_wd, mem_rd;
    logic        cpu_ack, dma_ack, mem_we, busy;
    logic        b_cpu_req = 0, b_cpu_we = 0, b_dma_req = 0, b_dma_we = 0;
    logic [31:0] b_cpu_adr = 0, b_cpu_wd = 0, b_dma_adr = 0, b_dma_wd = 0;
    logic [31:0] b_cpu_rd, b_dma_rd, b_mem_adr, b_mem_wd, b_mem_rd;
    logic        b_cpu_ack, b_dma_ack, b_mem_we, b_busy;
    logic [31:0] mem [256];
    logic [31:0] bmem [256];
    int          we_cnt = 0;
    int          compared = 0;
    int          mismatched = 0;

    mem_port_arbiter #(.WIDTH(32), .LAT(2)) u0 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
        .cpu_rd(cpu_rd), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wd(dma_wd),
        .dma_rd(dma_rd), .dma_ack(dma_ack),
        .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd), .busy(busy)
    );

    mem_port_arbiter #(.WIDTH(32), .LAT(1)) u1 (
        .clk(clk), .reset(reset),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_adr(b_cpu_adr), .cpu_wd(b_cpu_wd),
        .cpu_rd(b_cpu_rd), .cpu_ack(b_cpu_ack),
        .dma_req(b_dma_req), .dma_we(b_dma_we), .dma_adr(b_dma_adr), .dma_wd(b_dma_wd),
        .dma_rd(b_dma_rd), .dma_ack(b_dma_ack),
        .mem_adr(b_mem_adr), .mem_wd(b_mem_wd), .mem_we(b_mem_we), .mem_rd(b_mem_rd), .busy(b_busy)
    );

    always #5 clk = ~clk;

    assign mem_rd   = mem[mem_adr[7:0]];
    assign b_mem_rd = bmem[b_mem_adr[7:0]];

    // Memory models commit writes on the clock edge; u0 also counts committed writes
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_adr[7:0]] <= mem_wd;
            we_cnt <= we_cnt + 1;
        end
        if (b_mem_we) bmem[b_mem_adr[7:0]] <= b_mem_wd;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int w0;
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 32'h0;
            bmem[i] = 32'h0;
        end
        mem[8'h10]  = 32'hDEADBEEF;
        bmem[8'h40] = 32'h0BADF00D;
        bmem[8'h50] = 32'hCAFE0001;

        // Reset state
        tick(); tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ack", {30'd0, cpu_ack, dma_ack}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_adr", mem_adr, 32'd0);
        chk("rst_wd", mem_wd, 32'd0);
        chk("rst_rd", cpu_rd | dma_rd, 32'd0);
        reset = 1'b1;

        // 1: single CPU read, ack three cycles after request
        cpu_req = 1; cpu_we = 0; cpu_adr = 32'h10;
        tick();
        chk("t1_c1_busy", {31'd0, busy}, 32'd1);
        chk("t1_c1_ack", {30'd0, cpu_ack, dma_ack}, 32'd0);
        tick();
        chk("t1_c2_ack", {30'd0, cpu_ack, dma_ack}, 32'd0);
        chk("t1_c2_adr", mem_adr, 32'h10);
        tick();
        chk("t1_ack", {30'd0, cpu_ack, dma_ack}, 32'b10);
        chk("t1_rd", cpu_rd, 32'hDEADBEEF);
        chk("t1_dma_rd", dma_rd, 32'd0);
        cpu_req = 0;
        tick();
        chk("t1_idle", {29'd0, busy, cpu_ack, dma_ack}, 32'd0);
        chk("t1_hold", cpu_rd, 32'hDEADBEEF);

        // 2: DMA write commits once, then CPU reads it back
        w0 = we_cnt;
        dma_req = 1; dma_we = 1; dma_adr = 32'h20; dma_wd = 32'h12345678;
        tick();
        chk("t2_c1_we", {31'd0, mem_we}, 32'd0);
        tick();
        chk("t2_c2_we", {31'd0, mem_we}, 32'd1);
        chk("t2_adr", mem_adr, 32'h20);
        chk("t2_wd", mem_wd, 32'h12345678);
        tick();
        chk("t2_ack", {30'd0, cpu_ack, dma_ack}, 32'b01);
        chk("t2_resp_we", {31'd0, mem_we}, 32'd0);
        chk("t2_we_cnt", 32'(we_cnt - w0), 32'd1);
        dma_req = 0; dma_we = 0;
        tick();
        cpu_req = 1; cpu_adr = 32'h20;
        tick(); tick(); tick();
        chk("t2_rb_ack", {30'd0, cpu_ack, dma_ack}, 32'b10);
        chk("t2_rb_rd", cpu_rd, 32'h12345678);
        cpu_req = 0;
        tick();

        // 3: both requesting from reset, grants alternate starting with CPU
        reset = 0;
        cpu_req = 1; cpu_adr = 32'h10; dma_req = 1; dma_we = 0; dma_adr = 32'h20;
        tick();
        reset = 1;
        for (int k = 1; k <= 23; k++) begin
            tick();
            chk($sformatf("t3_k%0d", k), {30'd0, cpu_ack, dma_ack},
                (k % 4 != 3) ? 32'b00 : ((k / 4) % 2 == 0) ? 32'b10 : 32'b01);
        end
        cpu_req = 0; dma_req = 0;
        tick();
        chk("t3_idle", {31'd0, busy}, 32'd0);
        chk("t3_cpu_rd", cpu_rd, 32'hDEADBEEF);
        chk("t3_dma_rd", dma_rd, 32'h12345678);

        // 4: asynchronous reset during a CPU write aborts it
        w0 = we_cnt;
        cpu_req = 1; cpu_we = 1; cpu_adr = 32'h30; cpu_wd = 32'hAAAA5555;
        tick();
        chk("t4_busy", {31'd0, busy}, 32'd1);
        #3 reset = 0;
        #1;
        chk("t4_async_busy", {31'd0, busy}, 32'd0);
        chk("t4_async_adr", mem_adr | mem_wd, 32'd0);
        chk("t4_async_rd", cpu_rd | dma_rd, 32'd0);
        chk("t4_async_we", {31'd0, mem_we}, 32'd0);
        cpu_req = 0; cpu_we = 0;
        tick();
        chk("t4_no_ack", {30'd0, cpu_ack, dma_ack}, 32'd0);
        tick();
        chk("t4_no_write", 32'(we_cnt - w0), 32'd0);
        chk("t4_mem", mem[8'h30], 32'd0);
        reset = 1;
        cpu_req = 1; cpu_adr = 32'h10;
        tick(); tick();
        chk("t4_next_wait", {30'd0, cpu_ack, dma_ack}, 32'd0);
        tick();
        chk("t4_next_ack", {30'd0, cpu_ack, dma_ack}, 32'b10);
        chk("t4_next_rd", cpu_rd, 32'hDEADBEEF);
        cpu_req = 0;
        tick();

        // 5: LAT=1, DMA read then immediate CPU read
        b_dma_req = 1; b_dma_adr = 32'h40;
        tick();
        chk("t5_d1", {29'd0, b_busy, b_cpu_ack, b_dma_ack}, 32'b100);
        tick();
        chk("t5_dack", {30'd0, b_cpu_ack, b_dma_ack}, 32'b01);
        chk("t5_drd", b_dma_rd, 32'h0BADF00D);
        b_dma_req = 0; b_cpu_req = 1; b_cpu_adr = 32'h50;
        tick();
        chk("t5_idle", {29'd0, b_busy, b_cpu_ack, b_dma_ack}, 32'd0);
        tick();
        chk("t5_c1", {30'd0, b_cpu_ack, b_dma_ack}, 32'd0);
        tick();
        chk("t5_cack", {30'd0, b_cpu_ack, b_dma_ack}, 32'b10);
        chk("t5_crd", b_cpu_rd, 32'hCAFE0001);
        chk("t5_drd_kept", b_dma_rd, 32'h0BADF00D);
        b_cpu_req = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
